// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB prediction carry/resolve path.
package btb_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] BYTE_OFFSET = 32'd4;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            hit;
    logic [PC_W-1:0] target;
    logic            taken;
  } pred_entry_t;

  // Next PC for a given direction; the add wraps at 32 bits.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc,
                                               input logic taken,
                                               input logic [PC_W-1:0] target);
    return taken ? target : pc + BYTE_OFFSET;
  endfunction

endpackage

// File: rtl/btb_pred_pipe.sv
// Shift register carrying BTB predictions from IF to EX, one slot per stage.
module btb_pred_pipe
  import btb_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_advance,
  input  logic        i_flush,
  input  pred_entry_t i_entry,
  output pred_entry_t o_ex_entry
);

  pred_entry_t r_slot [STAGES];

  // Flush wins over advance so the entry fetched alongside a mispredict is dropped too.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_slot[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < STAGES; i++) r_slot[i].valid <= 1'b0;
    end else if (i_advance) begin
      r_slot[0] <= i_entry;
      for (int i = 1; i < STAGES; i++) r_slot[i] <= r_slot[i-1];
    end
  end

  assign o_ex_entry = r_slot[STAGES-1];

endmodule

// File: rtl/btb_resolve_unit.sv
// Resolves carried BTB predictions against the EX outcome; drives BTB training, redirect and counters.
module btb_resolve_unit
  import btb_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_if_valid,
  input  logic [31:0]      i_if_pc,
  input  logic             i_btb_hit,
  input  logic [31:0]      i_btb_target,
  input  logic             i_btb_taken,
  input  logic             i_stall,
  input  logic             i_ex_is_branch,
  input  logic             i_ex_taken,
  input  logic [31:0]      i_ex_target,
  output logic             o_update,
  output logic [31:0]      o_update_pc,
  output logic [31:0]      o_update_target,
  output logic             o_mispredicted,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispredict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pred_entry_t     w_in_entry;
  pred_entry_t     w_ex;
  logic            w_resolve;
  logic            w_act_taken;
  logic [PC_W-1:0] w_pred_next;
  logic [PC_W-1:0] w_act_next;
  logic            w_mispredict;

  logic             r_update;
  logic [PC_W-1:0]  r_update_pc;
  logic [PC_W-1:0]  r_update_target;
  logic             r_mispredicted;
  logic             r_redirect;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  // While redirect is high the fetch stage is still on the wrong path.
  always_comb begin
    w_in_entry.valid  = i_if_valid & ~r_redirect;
    w_in_entry.pc     = i_if_pc;
    w_in_entry.hit    = i_btb_hit;
    w_in_entry.target = i_btb_target;
    w_in_entry.taken  = i_btb_taken;
  end

  btb_pred_pipe #(.STAGES(STAGES)) u_pipe (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_advance  (~i_stall),
    .i_flush    (w_resolve & w_mispredict),
    .i_entry    (w_in_entry),
    .o_ex_entry (w_ex)
  );

  assign w_resolve    = ~i_stall & w_ex.valid & ~r_redirect;
  assign w_act_taken  = i_ex_is_branch & i_ex_taken;
  assign w_pred_next  = next_pc(w_ex.pc, w_ex.taken, w_ex.target);
  assign w_act_next   = next_pc(w_ex.pc, w_act_taken, i_ex_target);
  assign w_mispredict = (w_pred_next != w_act_next);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_update         <= 1'b0;
      r_update_pc      <= '0;
      r_update_target  <= '0;
      r_mispredicted   <= 1'b0;
      r_redirect       <= 1'b0;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_update       <= w_resolve & (w_act_taken | w_ex.hit);
      r_mispredicted <= w_resolve & w_mispredict;
      r_redirect     <= w_resolve & w_mispredict;
      if (w_resolve) begin
        r_update_pc     <= w_ex.pc;
        r_update_target <= w_act_next;
        r_redirect_pc   <= w_act_next;
      end
      if (w_resolve & i_ex_is_branch & (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      if (w_resolve & w_mispredict & (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
    end
  end

  assign o_update         = r_update;
  assign o_update_pc      = r_update_pc;
  assign o_update_target  = r_update_target;
  assign o_mispredicted   = r_mispredicted;
  assign o_redirect       = r_redirect;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_branch_cnt     = r_branch_cnt;
  assign o_mispredict_cnt = r_mispredict_cnt;

endmodule
